// File: rtl/adc_serial_pkg.sv
// Shared constants and state encoding for the ADC serial responder.
// Frame layout: leading zeros then conversion data, MSB first.
package adc_serial_pkg;

  localparam int FRAME_BITS      = 16;
  localparam int ADDR_FIRST_RISE = 3;
  localparam int ADDR_BITS       = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } adc_rsp_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop pin synchronizer followed by a one-flop edge detector.
// Rise/fall are single-clk pulses derived from the synchronized level.
module sync_edge_detect #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= STAGES'({r_sync, i_d});
      r_prev <= w_level;
    end
  end

endmodule

// File: rtl/adc_serial_responder.sv
// Converter end of an ADC128S022-style 4-wire link for loopback tests.
// Channel values come in parallel; frames are shifted out on SDAT.
module adc_serial_responder
  import adc_serial_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     adc_cs_n,
  input  logic                     adc_sclk,
  input  logic                     adc_saddr,
  output logic                     adc_sdat,
  output logic                     adc_sdat_oe,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [ADDR_BITS-1:0]     cur_chan,
  output logic                     frame_done,
  output logic                     frame_abort,
  output logic [15:0]              frame_count
);

  localparam logic [4:0] LAST_RISE = 5'(FRAME_BITS - 1);
  localparam logic [4:0] FULL_RISE = 5'(FRAME_BITS);
  localparam logic [4:0] ADDR_LO   = 5'(ADDR_FIRST_RISE - 1);
  localparam logic [4:0] ADDR_HI   = 5'(ADDR_FIRST_RISE - 2 + ADDR_BITS);
  localparam logic [ADDR_BITS-1:0] CH_MASK = ADDR_BITS'(NUM_CH - 1);

  adc_rsp_state_t          r_state;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [4:0]              r_rise_cnt;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [ADDR_BITS-1:0]    r_cur_chan;
  logic                    r_sdat;
  logic                    r_oe;
  logic                    r_done;
  logic                    r_abort;
  logic [15:0]             r_count;
  logic [SYNC_STAGES-1:0]  r_saddr_sync;

  logic                    w_cs_rise;
  logic                    w_cs_fall;
  logic                    w_sclk_rise;
  logic                    w_sclk_fall;
  logic                    w_saddr;
  logic [DATA_W-1:0]       w_ch_val;
  logic [FRAME_BITS-1:0]   w_load;
  logic                    w_addr_win;

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (adc_cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  sync_edge_detect #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .reset  (reset),
    .i_d    (adc_sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  assign w_saddr    = r_saddr_sync[SYNC_STAGES-1];
  assign w_ch_val   = ch_data[int'(r_cur_chan)*DATA_W +: DATA_W];
  assign w_load     = FRAME_BITS'(w_ch_val);
  assign w_addr_win = (r_rise_cnt >= ADDR_LO) && (r_rise_cnt <= ADDR_HI);

  assign adc_sdat    = r_sdat;
  assign adc_sdat_oe = r_oe;
  assign cur_chan    = r_cur_chan;
  assign frame_done  = r_done;
  assign frame_abort = r_abort;
  assign frame_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_saddr_sync <= '0;
    end else begin
      r_saddr_sync <= SYNC_STAGES'({r_saddr_sync, adc_saddr});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_rise_cnt <= '0;
      r_addr     <= '0;
      r_cur_chan <= '0;
      r_sdat     <= 1'b1;
      r_oe       <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_cs_fall) r_state <= LOAD;
        end
        LOAD: begin
          if (w_cs_rise) begin
            r_state <= IDLE;
            r_sdat  <= 1'b1;
            r_oe    <= 1'b0;
          end else begin
            r_shift    <= w_load;
            r_sdat     <= w_load[FRAME_BITS-1];
            r_oe       <= 1'b1;
            r_rise_cnt <= '0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          // completion wins over a coincident CS_N rise
          if (w_sclk_rise && r_rise_cnt == LAST_RISE) begin
            r_rise_cnt <= FULL_RISE;
            r_cur_chan <= r_addr & CH_MASK;
            r_done     <= 1'b1;
            r_count    <= r_count + 16'd1;
            if (w_cs_rise) begin
              r_state <= IDLE;
              r_sdat  <= 1'b1;
              r_oe    <= 1'b0;
            end else begin
              r_state <= LOAD;
            end
          end else if (w_cs_rise) begin
            r_state <= IDLE;
            r_sdat  <= 1'b1;
            r_oe    <= 1'b0;
            r_abort <= (r_rise_cnt != 5'd0);
          end else if (w_sclk_rise) begin
            r_rise_cnt <= r_rise_cnt + 5'd1;
            if (w_addr_win) r_addr <= {r_addr[ADDR_BITS-2:0], w_saddr};
          end else if (w_sclk_fall && r_rise_cnt != 5'd0) begin
            r_shift <= r_shift << 1;
            r_sdat  <= r_shift[FRAME_BITS-2];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench: a bit-banged SPI master drives frames at SCLK=clk/8,
// expected words go through a scoreboard queue.
module tb_adc_serial_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs_n;
  logic        sclk;
  logic        saddr;
  logic        sdat;
  logic        oe;
  logic [95:0] ch_data;
  logic [2:0]  cur_chan;
  logic        done;
  logic        abort;
  logic [15:0] fcount;

  logic [11:0] ch [8];
  logic [15:0] sb_q [$];

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_abort  = 0;

  adc_serial_responder dut (
    .clk         (clk),
    .reset       (reset),
    .adc_cs_n    (cs_n),
    .adc_sclk    (sclk),
    .adc_saddr   (saddr),
    .adc_sdat    (sdat),
    .adc_sdat_oe (oe),
    .ch_data     (ch_data),
    .cur_chan    (cur_chan),
    .frame_done  (done),
    .frame_abort (abort),
    .frame_count (fcount)
  );

  always #5 clk = ~clk;

  always_comb begin
    ch_data = '0;
    for (int i = 0; i < 8; i++) ch_data[i*12 +: 12] = ch[i];
  end

  always @(posedge clk) begin
    if (done)  n_done  <= n_done + 1;
    if (abort) n_abort <= n_abort + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [15:0] word);
    logic [15:0] e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, word);
    end else begin
      e = sb_q.pop_front();
      chk(tag, 32'(word), 32'(e));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cs_n  = 1'b1;
    sclk  = 1'b0;
    saddr = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [2:0] a, input int nrise,
                           input bit idle_hi, input bit keep_cs,
                           input int rst_at, input int chg_at,
                           input logic [11:0] chg_val,
                           output logic [15:0] word);
    word = '0;
    if (cs_n) begin
      sclk = idle_hi;
      @(negedge clk);
      cs_n = 1'b0;
      repeat (8) @(negedge clk);
      if (idle_hi) sclk = 1'b0;
    end
    for (int k = 1; k <= nrise; k++) begin
      saddr = (k >= 3 && k <= 5) ? a[5-k] : 1'b0;
      repeat (4) @(negedge clk);
      word[16-k] = sdat;
      sclk = 1'b1;
      if (k == chg_at) ch[0] = chg_val;
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_sdat", 32'(sdat), 32'd1);
        chk("rst_chan", 32'(cur_chan), 32'd0);
        chk("rst_count", 32'(fcount), 32'd0);
        sclk = 1'b0;
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        return;
      end
      repeat (4) @(negedge clk);
      if (!(idle_hi && k == nrise)) sclk = 1'b0;
    end
    if (!keep_cs) begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] w;
    int ab0;
    int d0;
    for (int i = 0; i < 8; i++) ch[i] = 12'h000;
    ch[0] = 12'hA5C;
    ch[3] = 12'h123;
    do_reset();
    chk("reset_sdat", 32'(sdat), 32'd1);
    chk("reset_oe", 32'(oe), 32'd0);
    chk("reset_chan", 32'(cur_chan), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_abort", 32'(abort), 32'd0);
    chk("reset_count", 32'(fcount), 32'd0);

    // single frames with address 3
    sb_q.push_back(16'h0A5C);
    run_frame(3'd3, 16, 1'b0, 1'b0, 0, 0, 12'h0, w);
    sb_check("t1_frame0", w);
    chk("t1_chan", 32'(cur_chan), 32'd3);
    chk("t1_ndone", 32'(n_done), 32'd1);
    chk("t1_count", 32'(fcount), 32'd1);
    sb_q.push_back(16'h0123);
    run_frame(3'd3, 16, 1'b0, 1'b0, 0, 0, 12'h0, w);
    sb_check("t1_frame1", w);
    chk("t1_count2", 32'(fcount), 32'd2);
    chk("t1_nabort", 32'(n_abort), 32'd0);

    // continuous mode: 32 SCLKs under one CS_N
    ch[5] = 12'hFFF;
    do_reset();
    sb_q.push_back(16'h0A5C);
    run_frame(3'd5, 16, 1'b0, 1'b1, 0, 0, 12'h0, w);
    sb_check("t2_frame0", w);
    sb_q.push_back(16'h0FFF);
    run_frame(3'd7, 16, 1'b0, 1'b0, 0, 0, 12'h0, w);
    sb_check("t2_frame1", w);
    chk("t2_chan", 32'(cur_chan), 32'd7);
    chk("t2_count", 32'(fcount), 32'd2);

    // abort after 9 rises carrying address 6
    ab0 = n_abort;
    d0  = n_done;
    run_frame(3'd6, 9, 1'b0, 1'b0, 0, 0, 12'h0, w);
    chk("t3_abort", 32'(n_abort), 32'(ab0 + 1));
    chk("t3_nodone", 32'(n_done), 32'(d0));
    chk("t3_chan", 32'(cur_chan), 32'd7);
    chk("t3_count", 32'(fcount), 32'd2);
    ch[7] = 12'h7E1;
    sb_q.push_back(16'h07E1);
    run_frame(3'd2, 16, 1'b0, 1'b0, 0, 0, 12'h0, w);
    sb_check("t3_after", w);
    chk("t3_chan2", 32'(cur_chan), 32'd2);

    // reset at rise 7
    run_frame(3'd5, 16, 1'b0, 1'b0, 7, 0, 12'h0, w);
    sb_q.push_back(16'h0A5C);
    run_frame(3'd0, 16, 1'b0, 1'b0, 0, 0, 12'h0, w);
    sb_check("t4_after", w);
    chk("t4_count", 32'(fcount), 32'd1);
    chk("t4_chan", 32'(cur_chan), 32'd0);

    // channel data changes mid-frame
    sb_q.push_back(16'h0A5C);
    run_frame(3'd0, 16, 1'b0, 1'b0, 0, 4, 12'h3C3, w);
    sb_check("t5_old", w);
    sb_q.push_back(16'h03C3);
    run_frame(3'd0, 16, 1'b0, 1'b0, 0, 0, 12'h0, w);
    sb_check("t5_new", w);

    // SCLK idling high, then low
    sb_q.push_back(16'h03C3);
    run_frame(3'd0, 16, 1'b1, 1'b0, 0, 0, 12'h0, w);
    sb_check("t6_idle_hi", w);
    sb_q.push_back(16'h03C3);
    run_frame(3'd0, 16, 1'b0, 1'b0, 0, 0, 12'h0, w);
    sb_check("t6_idle_lo", w);
    chk("t6_count", 32'(fcount), 32'd5);
    chk("t6_oe_idle", 32'(oe), 32'd0);
    chk("t6_sdat_idle", 32'(sdat), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
